// File: rtl/dmem_responder_if.sv
// Data-port and console-drain bundle between the core side and dmem_responder.
//
// Signals:
//   adrdata   - byte address from the core M stage
//   writedata - store data
//   we        - store strobe
//   ecall     - ecall retiring in W (sets halt)
//   readdata  - combinational load data
//   con_data  - console FIFO head byte
//   con_valid - console FIFO not empty
//   con_ready - console consumer accepts the head byte
//   halted    - sticky halt flag
//
// Modports:
//   master - core / console consumer side
//   slave  - dmem_responder side
interface dmem_responder_if #(
   parameter int unsigned DATA_W = 32
);
   logic [DATA_W-1:0] adrdata;
   logic [DATA_W-1:0] writedata;
   logic              we;
   logic              ecall;
   logic [DATA_W-1:0] readdata;
   logic [7:0]        con_data;
   logic              con_valid;
   logic              con_ready;
   logic              halted;

   modport master (
      output adrdata, writedata, we, ecall, con_ready,
      input  readdata, con_data, con_valid, halted
   );

   modport slave (
      input  adrdata, writedata, we, ecall, con_ready,
      output readdata, con_data, con_valid, halted
   );
endinterface

// File: rtl/dmem_responder.sv
// Data-side responder for the rv32i pipeline core: word-addressed data RAM plus a small
// MMIO page (console TX FIFO, free-running cycle counter, halt register).
//
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset (RAM contents are not reset)
//   bus   - dmem_responder_if.slave: core data port, ecall, console drain, halted
//
// MMIO word offsets from MMIO_BASE: 0x00 CON_TX, 0x04 CON_STAT, 0x08 CYCLE, 0x0C HALT,
// 0x10 ERR (only with DMEM_MISALIGN_TRAP_EN).
//
// Build option DMEM_MISALIGN_TRAP_EN: misaligned RAM stores are suppressed and halt the
// core; misaligned loads are flagged. Both are reported in ERR.
module dmem_responder #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       MEM_WORDS = 1024,
   parameter int unsigned       CON_DEPTH = 8,
   parameter logic [DATA_W-1:0] MMIO_BASE = 32'hFFFF_0000
) (
   input logic              clk,
   input logic              rst_n,
   dmem_responder_if.slave  bus
);

   localparam int unsigned       AW        = $clog2(MEM_WORDS);
   localparam int unsigned       PW        = $clog2(CON_DEPTH);
   localparam int unsigned       CW        = PW + 1;
   localparam logic [DATA_W-1:0] RAM_LIMIT = DATA_W'(64'(MEM_WORDS) * 64'd4);
   localparam logic [CW-1:0]     FULL_CNT  = CW'(CON_DEPTH);

   localparam logic [5:0] OffConTx   = 6'h00;
   localparam logic [5:0] OffConStat = 6'h01;
   localparam logic [5:0] OffCycle   = 6'h02;
   localparam logic [5:0] OffHalt    = 6'h03;
`ifdef DMEM_MISALIGN_TRAP_EN
   localparam logic [5:0] OffErr     = 6'h04;
`endif

   // Address decode
   logic          is_ram;
   logic          is_mmio;
   logic [AW-1:0] ram_idx;
   logic [5:0]    mmio_word;
   logic          mmio_we;
   logic          ram_we;

   assign is_ram    = bus.adrdata < RAM_LIMIT;
   assign is_mmio   = bus.adrdata[DATA_W-1:8] == MMIO_BASE[DATA_W-1:8];
   assign ram_idx   = bus.adrdata[AW+1:2];
   // Low two address bits do not select within the MMIO page.
   assign mmio_word = bus.adrdata[7:2];
   assign mmio_we   = bus.we & is_mmio & ~is_ram;

   logic con_push_req;
   logic stat_we;
   logic cycle_we;
   logic halt_we;

   assign con_push_req = mmio_we & (mmio_word == OffConTx);
   assign stat_we      = mmio_we & (mmio_word == OffConStat);
   assign cycle_we     = mmio_we & (mmio_word == OffCycle);
   assign halt_we      = mmio_we & (mmio_word == OffHalt);

`ifdef DMEM_MISALIGN_TRAP_EN
   logic       misaligned;
   logic       store_trap;
   logic       load_mis;
   logic       err_we;
   logic [1:0] err_q, err_d;

   assign misaligned = bus.adrdata[1:0] != 2'b00;
   assign store_trap = bus.we & is_ram & misaligned;
   assign load_mis   = ~bus.we & (is_ram | is_mmio) & misaligned;
   assign err_we     = mmio_we & (mmio_word == OffErr);
   assign ram_we     = bus.we & is_ram & ~misaligned;

   always_comb begin
      err_d = err_q | {load_mis, store_trap};
      if (err_we) begin
         err_d = 2'b00;
      end
   end
`else
   assign ram_we = bus.we & is_ram;
`endif

   // Data RAM: synchronous write, asynchronous read, no reset.
   logic [DATA_W-1:0] ram_q [MEM_WORDS];

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[ram_idx] <= bus.writedata;
      end
   end

   // Console FIFO
   logic [7:0]    con_buf_q [CON_DEPTH];
   logic [7:0]    con_buf_d [CON_DEPTH];
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          con_full;
   logic          con_empty;
   logic          con_pop;
   logic          con_push_ok;

   assign con_full    = cnt_q == FULL_CNT;
   assign con_empty   = cnt_q == '0;
   assign con_pop     = ~con_empty & bus.con_ready;
   // A full FIFO still takes a byte when the head leaves in the same cycle.
   assign con_push_ok = con_push_req & (~con_full | con_pop);

   always_comb begin
      con_buf_d = con_buf_q;
      head_d    = head_q;
      tail_d    = tail_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      if (con_pop) begin
         head_d = head_q + 1'b1;
      end
      if (con_push_ok) begin
         con_buf_d[tail_q] = bus.writedata[7:0];
         tail_d            = tail_q + 1'b1;
      end
      case ({con_push_ok, con_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
      if (con_push_req && !con_push_ok) begin
         ovf_d = 1'b1;
      end
      if (stat_we) begin
         ovf_d = 1'b0;
      end
   end

   // Cycle counter and halt
   logic [DATA_W-1:0] cycle_q, cycle_d;
   logic              halted_q, halted_d;

   always_comb begin
      cycle_d = cycle_q;
      if (cycle_we) begin
         cycle_d = bus.writedata;
      end else if (!halted_q) begin
         cycle_d = cycle_q + 1'b1;
      end
      halted_d = halted_q | bus.ecall | halt_we;
`ifdef DMEM_MISALIGN_TRAP_EN
      halted_d = halted_d | store_trap;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         con_buf_q <= '{default: '0};
         head_q    <= '0;
         tail_q    <= '0;
         cnt_q     <= '0;
         ovf_q     <= 1'b0;
         cycle_q   <= '0;
         halted_q  <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
         err_q     <= 2'b00;
`endif
      end else begin
         con_buf_q <= con_buf_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         cnt_q     <= cnt_d;
         ovf_q     <= ovf_d;
         cycle_q   <= cycle_d;
         halted_q  <= halted_d;
`ifdef DMEM_MISALIGN_TRAP_EN
         err_q     <= err_d;
`endif
      end
   end

   // Load data
   logic [DATA_W-1:0] con_stat;
   logic [DATA_W-1:0] rdata;

   assign con_stat = DATA_W'({8'(cnt_q), 5'b0, ovf_q, con_empty, con_full});

   always_comb begin
      rdata = '0;
      if (is_ram) begin
         rdata = ram_q[ram_idx];
      end else if (is_mmio) begin
         case (mmio_word)
            OffConStat: rdata = con_stat;
            OffCycle:   rdata = cycle_q;
            OffHalt:    rdata = DATA_W'(halted_q);
`ifdef DMEM_MISALIGN_TRAP_EN
            OffErr:     rdata = DATA_W'(err_q);
`endif
            default:    rdata = '0;
         endcase
      end
   end

   assign bus.readdata  = rdata;
   assign bus.con_data  = con_buf_q[head_q];
   assign bus.con_valid = ~con_empty;
   assign bus.halted    = halted_q;

endmodule

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
module tb_dmem_responder;

   localparam logic [31:0] ConTx   = 32'hFFFF_0000;
   localparam logic [31:0] ConStat = 32'hFFFF_0004;
   localparam logic [31:0] Cyc     = 32'hFFFF_0008;
   localparam logic [31:0] Halt    = 32'hFFFF_000C;
   localparam logic [31:0] Err     = 32'hFFFF_0010;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic chk_en = 1'b0;
   int   n_total = 0;
   int   n_pass  = 0;

   always #5 clk = ~clk;

   dmem_responder_if #(.DATA_W(32)) bus ();

   dmem_responder #(
      .DATA_W    (32),
      .MEM_WORDS (1024),
      .CON_DEPTH (8),
      .MMIO_BASE (32'hFFFF_0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Behavioural model: RAM as a sparse word map, console as a byte queue.
   logic [31:0] m_ram [int];
   logic [7:0]  m_q [$];
   logic        m_ovf   = 1'b0;
   logic        m_halt  = 1'b0;
   logic [31:0] m_cycle = 32'h0;
   logic [1:0]  m_err   = 2'b00;

   task automatic model_step();
      logic [31:0] a;
      logic [31:0] wd;
      logic        w;
      logic        ram;
      logic        mmio;
      logic        mis;
      logic        was_halted;
      logic        cyc_wr;
      a          = bus.adrdata;
      wd         = bus.writedata;
      w          = bus.we;
      ram        = a < 32'h1000;
      mmio       = a[31:8] == 24'hFFFF00;
      mis        = a[1:0] != 2'b00;
      was_halted = m_halt;
      cyc_wr     = w && mmio && a[7:2] == 6'h02;
      if (m_q.size() != 0 && bus.con_ready) void'(m_q.pop_front());
      if (w && mmio) begin
         case (a[7:2])
            6'h00: if (m_q.size() < 8) m_q.push_back(wd[7:0]); else m_ovf = 1'b1;
            6'h01: m_ovf = 1'b0;
            6'h02: m_cycle = wd;
            6'h03: m_halt = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
            6'h04: m_err = 2'b00;
`endif
            default: ;
         endcase
      end
      if (!cyc_wr && !was_halted) m_cycle = m_cycle + 32'd1;
      if (w && ram) begin
`ifdef DMEM_MISALIGN_TRAP_EN
         if (mis) begin
            m_err[0] = 1'b1;
            m_halt   = 1'b1;
         end else
`endif
         m_ram[int'(a[11:2])] = wd;
      end
`ifdef DMEM_MISALIGN_TRAP_EN
      if (!w && (ram || mmio) && mis) m_err[1] = 1'b1;
`else
      if (mis) m_err = 2'b00;
`endif
      if (bus.ecall) m_halt = 1'b1;
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_ovf   = 1'b0;
         m_halt  = 1'b0;
         m_cycle = 32'h0;
         m_err   = 2'b00;
      end else begin
         model_step();
      end
   end

   // Returns {known, value}; RAM words never written are unknown.
   function automatic logic [32:0] model_rd(input logic [31:0] a);
      logic [31:0] stat;
      if (a < 32'h1000) begin
         if (m_ram.exists(int'(a[11:2]))) return {1'b1, m_ram[int'(a[11:2])]};
         return 33'h0;
      end
      if (a[31:8] != 24'hFFFF00) return {1'b1, 32'h0};
      stat = {16'h0, 8'(m_q.size()), 5'h0, m_ovf, m_q.size() == 0, m_q.size() == 8};
      case (a[7:2])
         6'h01: return {1'b1, stat};
         6'h02: return {1'b1, m_cycle};
         6'h03: return {2'b01, 30'h0, m_halt};
`ifdef DMEM_MISALIGN_TRAP_EN
         6'h04: return {1'b1, 30'h0, m_err};
`endif
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   // Compare process: outputs against the model on every falling edge.
   always @(negedge clk) begin
      logic [32:0] e;
      if (chk_en) begin
         e = model_rd(bus.adrdata);
         if (e[32]) check("readdata", bus.readdata, e[31:0]);
         check("con_valid", 32'(bus.con_valid), 32'(m_q.size() != 0));
         if (m_q.size() != 0) check("con_data", 32'(bus.con_data), 32'(m_q[0]));
         check("halted", 32'(bus.halted), 32'(m_halt));
      end
   end

   task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic w);
      bus.adrdata   = a;
      bus.writedata = wd;
      bus.we        = w;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input string name, input logic [31:0] exp);
      @(negedge clk);
      #1;
      check(name, bus.readdata, exp);
   endtask

   task automatic drain8(input string name, input logic [7:0] first, input logic [7:0] last);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #1;
         check(name, 32'(bus.con_data), (i == 7) ? 32'(last) : 32'(first + 8'(i)));
         tick();
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      tick();
   endtask

   logic [31:0] snap;

   initial begin
      drive(32'h0, 32'h0, 1'b0);
      bus.ecall     = 1'b0;
      bus.con_ready = 1'b0;
      #12;
      check("rst_con_valid", 32'(bus.con_valid), 32'h0);
      check("rst_con_data", 32'(bus.con_data), 32'h0);
      check("rst_halted", 32'(bus.halted), 32'h0);
      drive(Cyc, 32'h0, 1'b0);
      @(negedge clk);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Cycle counter
      repeat (10) @(posedge clk);
      #1;
      peek("cycle_after_10", 32'd10);
      tick();
      drive(Cyc, 32'hFFFF_FFFE, 1'b1); tick();
      drive(Cyc, 32'h0, 1'b0);
      peek("cycle_load", 32'hFFFF_FFFE);
      tick(); tick();
      peek("cycle_wrap", 32'h0);
      tick();

      // RAM and decode
      drive(32'h44, 32'h1234_5678, 1'b1); tick();
      drive(32'h40, 32'hDEAD_BEEF, 1'b1); tick();
      drive(32'h40, 32'h0, 1'b0);
      peek("ram_40", 32'hDEAD_BEEF); tick();
      drive(32'h44, 32'h0, 1'b0);
      peek("ram_44", 32'h1234_5678); tick();
      drive(32'h1000_0000, 32'h0, 1'b0);
      peek("unmapped_rd", 32'h0); tick();
      drive(32'hFFC, 32'hA5A5_0FF0, 1'b1); tick();
      drive(32'h0, 32'h0, 1'b1); tick();
      drive(32'h1000, 32'h1111_1111, 1'b1); tick();
      drive(32'hFFC, 32'h0, 1'b0);
      peek("ram_last", 32'hA5A5_0FF0); tick();
      drive(32'h0, 32'h0, 1'b0);
      peek("no_alias_0", 32'h0); tick();

      // FIFO fill, overflow, in-order drain
      for (int i = 0; i < 8; i++) begin
         drive(ConTx, 32'h41 + 32'(i), 1'b1);
         tick();
      end
      drive(ConStat, 32'h0, 1'b0);
      peek("stat_full", 32'h0000_0801); tick();
      drive(ConTx, 32'h49, 1'b1); tick();
      drive(ConStat, 32'h0, 1'b0);
      peek("stat_ovf", 32'h0000_0805); tick();
      bus.con_ready = 1'b1;
      drain8("drain_ah", 8'h41, 8'h48);
      check("drained_valid", 32'(bus.con_valid), 32'h0);
      peek("stat_empty_ovf", 32'h0000_0006); tick();
      drive(ConStat, 32'h0, 1'b1); tick();
      drive(ConStat, 32'h0, 1'b0);
      peek("stat_ovf_clr", 32'h0000_0002); tick();

      // Full FIFO: push accepted alongside a pop
      bus.con_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(ConTx, 32'h30 + 32'(i), 1'b1);
         tick();
      end
      drive(ConTx, 32'h5A, 1'b1);
      bus.con_ready = 1'b1;
      tick();
      bus.con_ready = 1'b0;
      drive(ConStat, 32'h0, 1'b0);
      peek("stat_push_pop", 32'h0000_0801); tick();
      bus.con_ready = 1'b1;
      drain8("drain_z", 8'h31, 8'h5A);
      bus.con_ready = 1'b0;

      // ecall halt, frozen counter, drain continues, mid-drain reset
      for (int i = 0; i < 8; i++) begin
         drive(ConTx, 32'h61 + 32'(i), 1'b1);
         tick();
      end
      drive(Cyc, 32'h0, 1'b0);
      bus.ecall = 1'b1;
      tick();
      bus.ecall = 1'b0;
      check("ecall_halted", 32'(bus.halted), 32'h1);
      snap = m_cycle;
      bus.con_ready = 1'b1;
      repeat (5) tick();
      peek("cycle_frozen", snap);
      check("drain_after_halt", 32'(bus.con_data), 32'h66);
      drive(Cyc, 32'h55, 1'b1); tick();
      drive(Cyc, 32'h0, 1'b0);
      peek("cycle_wr_halted", 32'h55);
      rst_n = 1'b0;
      #1;
      check("midrst_valid", 32'(bus.con_valid), 32'h0);
      check("midrst_halted", 32'(bus.halted), 32'h0);
      check("midrst_cycle", bus.readdata, 32'h0);
      bus.con_ready = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      tick();

`ifdef DMEM_MISALIGN_TRAP_EN
      drive(32'h42, 32'hCAFE_F00D, 1'b1); tick();
      drive(32'h40, 32'h0, 1'b0);
      peek("mis_ram_kept", 32'hDEAD_BEEF);
      check("mis_halted", 32'(bus.halted), 32'h1);
      tick();
      drive(Err, 32'h0, 1'b0);
      peek("err_store", 32'h1); tick();
      drive(Err, 32'h0, 1'b1); tick();
      drive(Err, 32'h0, 1'b0);
      peek("err_clr", 32'h0); tick();
      drive(32'h41, 32'h0, 1'b0); tick();
      drive(Err, 32'h0, 1'b0);
      peek("err_load", 32'h2); tick();
      reset_pulse();
`else
      drive(Err, 32'h0, 1'b0);
      peek("err_absent", 32'h0); tick();
      drive(32'h42, 32'hCAFE_F00D, 1'b1); tick();
      drive(32'h40, 32'h0, 1'b0);
      peek("lowbits_ignored", 32'hCAFE_F00D); tick();
      reset_pulse();
`endif

      // HALT register write
      drive(Halt, 32'h0, 1'b1); tick();
      drive(Halt, 32'h0, 1'b0);
      peek("halt_rd", 32'h1);
      check("halt_wr_halted", 32'(bus.halted), 32'h1);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish");
      $fatal(1);
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-side responder for the rv32i pipeline core; it answers the core's M-stage data port (adrdata, writedata, we, readdata).
- Provides a word-addressed data RAM and a small MMIO page. The page holds a console TX FIFO with a valid/ready drain port, a free-running cycle counter, and a halt register.
- The halt register is also set by the core's W-stage ecall pulse.
- Sits beside the core in the top level, opposite the instruction memory.

Parameters:
- DATA_W, 32, data/address width.
- MEM_WORDS, 1024, RAM depth in 32-bit words; power of two.
- CON_DEPTH, 8, console FIFO depth in bytes; power of two, at least 2.
- MMIO_BASE, 32'hFFFF_0000, base of the MMIO page; compared on adrdata[31:8].

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- adrdata  in  DATA_W  byte address from the core M stage.
- writedata  in  DATA_W  store data.
- we  in  1  store strobe; one store per cycle while high.
- ecall  in  1  ecall retiring in W; sets halt.
- readdata  out  DATA_W  load data; combinational, same cycle as adrdata.
- con_data  out  8  FIFO head byte.
- con_valid  out  1  FIFO not empty.
- con_ready  in  1  consumer accepts the head byte.
- halted  out  1  sticky halt flag.

Behaviour:
- Address decode:
  - RAM when adrdata < MEM_WORDS*4. Index is adrdata[log2(MEM_WORDS)+1:2]; adrdata[1:0] is ignored.
  - MMIO when adrdata[31:8] == MMIO_BASE[31:8]. Offset is adrdata[7:0].
  - Anything else is unmapped: reads return 0, writes are dropped.
- RAM:
  - Writes occur at posedge when we=1.
  - Reads are asynchronous: a store at cycle N is visible to a load at cycle N+1.
  - RAM contents are not reset.
- MMIO map (word offsets; any other offset reads 0 and ignores writes):
  - 0x00 CON_TX:
    - Write pushes writedata[7:0].
    - Read returns 0.
  - 0x04 CON_STAT read value:
    - bit0 full.
    - bit1 empty.
    - bit2 overflow (sticky).
    - bits[15:8] count.
    - All other bits 0.
  - 0x04 CON_STAT write: any value clears overflow.
  - 0x08 CYCLE:
    - Read returns the counter.
    - Write loads writedata.
  - 0x0C HALT:
    - Write of any value sets halted.
    - Read returns {31'b0, halted}.
- Console FIFO:
  - Circular buffer with a count register; wrap pointers at CON_DEPTH.
  - Pop when con_valid & con_ready.
  - Push accepted when count < CON_DEPTH, or when full and a pop occurs in the same cycle.
  - Otherwise the byte is dropped, overflow is set, and count is unchanged.
  - Simultaneous push+pop leaves count unchanged and advances both pointers.
  - con_data is the head entry and is held stable while con_valid=1 and con_ready=0.
  - halted does not block pushes or pops; the FIFO keeps draining after halt.
- CYCLE counter:
  - Increments by 1 each cycle while halted=0; wraps 0xFFFFFFFF -> 0.
  - A CYCLE write takes priority over the increment in that cycle.
  - Frozen while halted=1; a CYCLE write is still honoured.
- Halt:
  - Set by ecall=1 or a HALT write.
  - Cleared only by reset.
- Reset values:
  - readdata follows decode; it is 0 for adrdata=0 only if RAM[0]=0.
  - con_valid=0, con_data=0 (storage cleared), halted=0.
  - CYCLE=0, count=0, pointers=0, overflow=0.
- Reset asserted mid-operation immediately clears all state except RAM; bytes in flight on the console are lost.

Optional Feature:
- Macro DMEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds MMIO 0x10 ERR. Read value: bit0 misaligned_store, bit1 misaligned_load. A write clears both bits.
  - A RAM store with adrdata[1:0]!=0 is suppressed (RAM unchanged), sets bit0, and sets halted the next cycle.
  - A RAM or MMIO access with we=0 and adrdata[1:0]!=0 sets bit1 and returns data as normal.
  - Both bits reset to 0.
- Undefined:
  - ERR reads 0.
  - Low address bits are ignored as above.
  - No trap.

Test Plan:
- Store 0xDEADBEEF to 0x40, then load 0x40 next cycle -> readdata=0xDEADBEEF. Load 0x44 -> prior RAM value. Load 0x1000_0000 -> 0.
- With con_ready=0, write 'A'..'H' to CON_TX -> count=8, full=1. Write 'I' -> dropped, overflow=1. Raise con_ready -> bytes 'A'..'H' appear in order, one per cycle. Then con_valid=0 and empty=1.
- With FIFO full and con_ready=1, push 'Z' in the same cycle as a pop -> accepted, count stays 8, and 'Z' is delivered 8th.
- Reset, then wait 10 cycles -> CYCLE read=10. Write 0xFFFFFFFE -> after 2 cycles reads 0. Write CON_STAT -> overflow cleared.
- Pulse ecall for 1 cycle -> halted=1 next edge. CYCLE is frozen across 5 cycles while the FIFO keeps draining. Assert rst_n=0 mid-drain -> con_valid=0, halted=0 immediately.
- (DMEM_MISALIGN_TRAP_EN) Store to 0x42 -> RAM[0x40] unchanged, ERR=1, halted=1. Write ERR -> ERR=0.
